// File: rtl/mem_miss_arbiter.sv
// Memory miss arbiter: shares one memory request port between several cache
// miss requesters (client 0 = I$, client 1 = D$, more appended) with
// round-robin arbitration and a single outstanding memory transaction.
//
// Ports
//   clock, reset         : clock, synchronous active-high reset
//   cl_req_valid/addr/   : per-client miss request, held until the client's
//   is_store/data          response; addr/data packed with client k at slice k
//   cl_rsp_valid         : one-hot, one-cycle response pulse per client
//   cl_rsp_data          : response line, shared by all clients
//   mem_req_*            : memory request (valid/ready handshake + payload)
//   mem_rsp_valid/data   : memory response, one per request (stores included)
//   rsp_client_id        : index of the client currently owning the memory port
//   spurious_rsp         : sticky flag, memory response seen while not waiting
module mem_miss_arbiter #(
  parameter int unsigned NUM_CLIENTS = 2,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned LINE_WIDTH  = 128
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_CLIENTS-1:0]            cl_req_valid,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] cl_req_addr,
  input  logic [NUM_CLIENTS-1:0]            cl_req_is_store,
  input  logic [NUM_CLIENTS*LINE_WIDTH-1:0] cl_req_data,
  output logic [NUM_CLIENTS-1:0]            cl_rsp_valid,
  output logic [LINE_WIDTH-1:0]             cl_rsp_data,
  output logic                              mem_req_valid,
  input  logic                              mem_req_ready,
  output logic [ADDR_WIDTH-1:0]             mem_req_addr,
  output logic                              mem_req_is_store,
  output logic [LINE_WIDTH-1:0]             mem_req_data,
  input  logic                              mem_rsp_valid,
  input  logic [LINE_WIDTH-1:0]             mem_rsp_data,
  output logic [((NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1)-1:0] rsp_client_id,
  output logic                              spurious_rsp
);

  localparam int unsigned ID_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2
  } state_t;

  state_t                 state;
  logic [ID_W-1:0]        ptr;
  logic [NUM_CLIENTS-1:0] req_masked_c;
  logic [ID_W-1:0]        idx_c;
  logic [ID_W-1:0]        win_c;
  logic [ID_W-1:0]        ptr_nxt_c;
  logic                   any_c;

  // Round-robin pick: lowest requesting index at or after ptr, wrapping.
  // A client whose response pulses this cycle is masked so its still-high
  // request level is not granted a second time.
  always_comb begin
    req_masked_c = cl_req_valid & ~cl_rsp_valid;
    idx_c        = '0;
    win_c        = '0;
    any_c        = 1'b0;
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      idx_c = ID_W'((32'(ptr) + i) % NUM_CLIENTS);
      if (!any_c && req_masked_c[idx_c]) begin
        any_c = 1'b1;
        win_c = idx_c;
      end
    end
    ptr_nxt_c = (win_c == ID_W'(NUM_CLIENTS - 1)) ? '0 : win_c + 1'b1;
  end

  // Control FSM; payload registers double as the memory request outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      ptr              <= '0;
      mem_req_valid    <= 1'b0;
      mem_req_addr     <= '0;
      mem_req_is_store <= 1'b0;
      mem_req_data     <= '0;
      cl_rsp_valid     <= '0;
      cl_rsp_data      <= '0;
      rsp_client_id    <= '0;
      spurious_rsp     <= 1'b0;
    end else begin
      cl_rsp_valid <= '0;
      // A response is only expected while waiting; anything else is dropped.
      if (mem_rsp_valid && (state != WAIT_RSP)) begin
        spurious_rsp <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (any_c) begin
            rsp_client_id    <= win_c;
            ptr              <= ptr_nxt_c;
            mem_req_addr     <= cl_req_addr[32'(win_c)*ADDR_WIDTH +: ADDR_WIDTH];
            mem_req_is_store <= cl_req_is_store[win_c];
            mem_req_data     <= cl_req_data[32'(win_c)*LINE_WIDTH +: LINE_WIDTH];
            mem_req_valid    <= 1'b1;
            state            <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (mem_rsp_valid) begin
            cl_rsp_valid <= NUM_CLIENTS'(1) << rsp_client_id;
            cl_rsp_data  <= mem_rsp_data;
            state        <= IDLE;
          end
        end
        default: begin
          mem_req_valid <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_miss_arbiter.sv
// Directed bench for mem_miss_arbiter (2 clients, 32-bit address, 128-bit line).
// Inputs are driven 1ns after the rising edge and outputs are sampled at the
// same point, so after each tick the bench sits inside the next cycle.
module tb_mem_miss_arbiter;

  localparam int unsigned NC = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned LW = 128;

  logic             clock;
  logic             reset;
  logic [NC-1:0]    cl_req_valid;
  logic [NC*AW-1:0] cl_req_addr;
  logic [NC-1:0]    cl_req_is_store;
  logic [NC*LW-1:0] cl_req_data;
  logic [NC-1:0]    cl_rsp_valid;
  logic [LW-1:0]    cl_rsp_data;
  logic             mem_req_valid;
  logic             mem_req_ready;
  logic [AW-1:0]    mem_req_addr;
  logic             mem_req_is_store;
  logic [LW-1:0]    mem_req_data;
  logic             mem_rsp_valid;
  logic [LW-1:0]    mem_rsp_data;
  logic [0:0]       rsp_client_id;
  logic             spurious_rsp;

  int n_cmp;
  int n_err;

  mem_miss_arbiter #(.NUM_CLIENTS(NC), .ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clock           (clock),
    .reset           (reset),
    .cl_req_valid    (cl_req_valid),
    .cl_req_addr     (cl_req_addr),
    .cl_req_is_store (cl_req_is_store),
    .cl_req_data     (cl_req_data),
    .cl_rsp_valid    (cl_rsp_valid),
    .cl_rsp_data     (cl_rsp_data),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_req_addr    (mem_req_addr),
    .mem_req_is_store(mem_req_is_store),
    .mem_req_data    (mem_req_data),
    .mem_rsp_valid   (mem_rsp_valid),
    .mem_rsp_data    (mem_rsp_data),
    .rsp_client_id   (rsp_client_id),
    .spurious_rsp    (spurious_rsp)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [LW-1:0] pat_a5;
  logic [LW-1:0] pat_dead;
  logic [LW-1:0] pat_c3;
  logic [NC-1:0] exp_oh;
  int            exp_id;

  initial begin
    n_cmp = 0;
    n_err = 0;
    pat_a5   = {16{8'hA5}};
    pat_dead = {8{16'hDEAD}};
    pat_c3   = {16{8'hC3}};

    reset           = 1'b1;
    cl_req_valid    = '0;
    cl_req_addr     = '0;
    cl_req_is_store = '0;
    cl_req_data     = '0;
    mem_req_ready   = 1'b0;
    mem_rsp_valid   = 1'b0;
    mem_rsp_data    = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_mem_req_valid", LW'(mem_req_valid), LW'(0));
    check("rst_cl_rsp_valid",  LW'(cl_rsp_valid), LW'(0));
    check("rst_cl_rsp_data",   cl_rsp_data, LW'(0));
    check("rst_client_id",     LW'(rsp_client_id), LW'(0));
    check("rst_spurious",      LW'(spurious_rsp), LW'(0));
    check("rst_mem_req_addr",  LW'(mem_req_addr), LW'(0));

    // Single fetch from client 0: request at N, issue N+1, response pulse N+3
    cl_req_valid         = 2'b01;
    cl_req_addr[31:0]    = 32'h1000;
    mem_req_ready        = 1'b1;
    tick();
    check("fetch_issue_valid", LW'(mem_req_valid), LW'(1));
    check("fetch_issue_addr",  LW'(mem_req_addr), LW'(32'h1000));
    check("fetch_issue_store", LW'(mem_req_is_store), LW'(0));
    check("fetch_issue_id",    LW'(rsp_client_id), LW'(0));
    tick();
    check("fetch_wait_valid",  LW'(mem_req_valid), LW'(0));
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = pat_a5;
    tick();
    check("fetch_rsp_valid",   LW'(cl_rsp_valid), LW'(2'b01));
    check("fetch_rsp_data",    cl_rsp_data, pat_a5);
    mem_rsp_valid = 1'b0;
    // Request still high during the pulse: must not be re-granted
    tick();
    check("fetch_pulse_len",   LW'(cl_rsp_valid), LW'(0));
    check("fetch_no_regrant",  LW'(mem_req_valid), LW'(0));
    check("fetch_no_spurious", LW'(spurious_rsp), LW'(0));
    cl_req_valid = '0;
    tick();

    // Contention from reset: grants alternate 0,1,0,1 back to back
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cl_req_valid       = 2'b11;
    cl_req_addr[31:0]  = 32'h0100;
    cl_req_addr[63:32] = 32'h0200;
    mem_req_ready      = 1'b1;
    for (int g = 0; g < 4; g++) begin
      exp_id = g % 2;
      exp_oh = (exp_id == 0) ? 2'b01 : 2'b10;
      tick();
      check("rr_issue_valid", LW'(mem_req_valid), LW'(1));
      check("rr_issue_id",    LW'(rsp_client_id), LW'(exp_id));
      check("rr_issue_addr",  LW'(mem_req_addr), LW'((exp_id == 0) ? 32'h0100 : 32'h0200));
      tick();
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = LW'(g + 16);
      tick();
      check("rr_rsp_valid", LW'(cl_rsp_valid), LW'(exp_oh));
      check("rr_rsp_data",  cl_rsp_data, LW'(g + 16));
      mem_rsp_valid = 1'b0;
      if (g == 3) cl_req_valid = '0;
    end
    tick();
    check("rr_idle_valid", LW'(mem_req_valid), LW'(0));
    check("rr_spurious",   LW'(spurious_rsp), LW'(0));

    // Backpressure: ready low for five ISSUE cycles, handshake on the sixth;
    // client inputs changed after latching must not leak into the payload
    mem_req_ready       = 1'b0;
    cl_req_valid        = 2'b01;
    cl_req_addr[31:0]   = 32'h3000;
    cl_req_data[127:0]  = pat_c3;
    tick();
    cl_req_addr[31:0]   = 32'hFFFF_FFFF;
    cl_req_data[127:0]  = '0;
    cl_req_is_store[0]  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", LW'(mem_req_valid), LW'(1));
      check("bp_addr",  LW'(mem_req_addr), LW'(32'h3000));
      check("bp_data",  mem_req_data, pat_c3);
      check("bp_store", LW'(mem_req_is_store), LW'(0));
      tick();
    end
    check("bp_c6_valid", LW'(mem_req_valid), LW'(1));
    check("bp_c6_addr",  LW'(mem_req_addr), LW'(32'h3000));
    mem_req_ready = 1'b1;
    tick();
    check("bp_wait_valid", LW'(mem_req_valid), LW'(0));
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = pat_c3;
    tick();
    check("bp_rsp_valid", LW'(cl_rsp_valid), LW'(2'b01));
    mem_rsp_valid      = 1'b0;
    cl_req_valid       = '0;
    cl_req_is_store[0] = 1'b0;
    tick();

    // Store from client 1
    cl_req_valid        = 2'b10;
    cl_req_is_store[1]  = 1'b1;
    cl_req_addr[63:32]  = 32'h4000;
    cl_req_data[255:128] = pat_dead;
    tick();
    check("st_valid", LW'(mem_req_valid), LW'(1));
    check("st_store", LW'(mem_req_is_store), LW'(1));
    check("st_data",  mem_req_data, pat_dead);
    check("st_addr",  LW'(mem_req_addr), LW'(32'h4000));
    check("st_id",    LW'(rsp_client_id), LW'(1));
    tick();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = '0;
    tick();
    check("st_rsp_valid", LW'(cl_rsp_valid), LW'(2'b10));
    mem_rsp_valid      = 1'b0;
    cl_req_valid       = '0;
    cl_req_is_store[1] = 1'b0;
    tick();
    check("st_id_hold", LW'(rsp_client_id), LW'(1));

    // Spurious response in IDLE: sticky flag, no client pulse
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = pat_a5;
    tick();
    check("sp_flag",      LW'(spurious_rsp), LW'(1));
    check("sp_rsp_valid", LW'(cl_rsp_valid), LW'(0));
    mem_rsp_valid = 1'b0;
    tick();
    tick();
    check("sp_sticky",    LW'(spurious_rsp), LW'(1));
    check("sp_rsp_valid2", LW'(cl_rsp_valid), LW'(0));

    // Reset while waiting for a response, then the late response arrives
    cl_req_valid      = 2'b01;
    cl_req_addr[31:0] = 32'h5000;
    tick();
    check("rw_issue_id", LW'(rsp_client_id), LW'(0));
    tick();
    cl_req_valid = '0;
    reset        = 1'b1;
    tick();
    reset = 1'b0;
    check("rw_rst_spurious", LW'(spurious_rsp), LW'(0));
    check("rw_rst_valid",    LW'(mem_req_valid), LW'(0));
    check("rw_rst_rsp_data", cl_rsp_data, LW'(0));
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = pat_dead;
    tick();
    check("rw_late_spurious", LW'(spurious_rsp), LW'(1));
    check("rw_late_no_rsp",   LW'(cl_rsp_valid), LW'(0));
    mem_rsp_valid = 1'b0;
    cl_req_valid  = 2'b11;
    tick();
    check("rw_next_valid", LW'(mem_req_valid), LW'(1));
    check("rw_next_id",    LW'(rsp_client_id), LW'(0));
    check("rw_next_addr",  LW'(mem_req_addr), LW'(32'h5000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
